// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: forwarding, stall/flush and HI/LO busy control for a 5-stage MIPS pipeline
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W   = 5,
  parameter int MULT_LATENCY = 4,
  parameter int DIV_LATENCY  = 32,
  parameter int COUNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  branch_decode,
  input  logic                  hilo_read_decode,
  input  logic                  muldiv_decode,
  input  logic [REG_ADDR_W-1:0] rs_decode,
  input  logic [REG_ADDR_W-1:0] rt_decode,
  input  logic [REG_ADDR_W-1:0] rs_execute,
  input  logic [REG_ADDR_W-1:0] rt_execute,
  input  logic [REG_ADDR_W-1:0] write_register_execute,
  input  logic                  register_write_execute,
  input  logic                  memory_to_register_execute,
  input  logic                  muldiv_start_execute,
  input  logic                  muldiv_is_div_execute,
  input  logic [REG_ADDR_W-1:0] write_register_memory,
  input  logic                  register_write_memory,
  input  logic                  memory_to_register_memory,
  input  logic                  mem_access_memory,
  input  logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] write_register_writeback,
  input  logic                  register_write_writeback,
  output logic                  stall_fetch,
  output logic                  stall_decode,
  output logic                  stall_execute,
  output logic                  stall_memory,
  output logic                  flush_execute,
  output logic                  flush_writeback,
  output logic                  forward_decode_a,
  output logic                  forward_decode_b,
  output logic [1:0]            forward_execute_a,
  output logic [1:0]            forward_execute_b,
  output logic                  muldiv_busy,
  output logic [COUNT_W-1:0]    stall_cycles
);
  localparam int CNT_W = DIV_LATENCY > 1 ? $clog2(DIV_LATENCY) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic mem_wait, lwstall, branchstall, hilostall, hazard, busy;
  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic [1:0] fwd_a, fwd_b;
  // hazard detection and forwarding select; outputs are held low while reset is asserted
  always_comb begin
    busy        = state_q == BUSY;
    mem_wait    = mem_access_memory && !mem_ready;
    lwstall     = memory_to_register_execute && rt_execute != '0 &&
                  (rs_decode == rt_execute || rt_decode == rt_execute);
    ex_hit_rs   = register_write_execute && write_register_execute != '0 && write_register_execute == rs_decode;
    ex_hit_rt   = register_write_execute && write_register_execute != '0 && write_register_execute == rt_decode;
    mem_hit_rs  = memory_to_register_memory && write_register_memory != '0 && write_register_memory == rs_decode;
    mem_hit_rt  = memory_to_register_memory && write_register_memory != '0 && write_register_memory == rt_decode;
    branchstall = branch_decode && (ex_hit_rs || ex_hit_rt || mem_hit_rs || mem_hit_rt);
    hilostall   = (hilo_read_decode || muldiv_decode) && busy;
    hazard      = !mem_wait && (lwstall || branchstall || hilostall);
    fwd_a = (rs_execute != '0 && rs_execute == write_register_memory && register_write_memory) ? 2'b10 :
            (rs_execute != '0 && rs_execute == write_register_writeback && register_write_writeback) ? 2'b01 : 2'b00;
    fwd_b = (rt_execute != '0 && rt_execute == write_register_memory && register_write_memory) ? 2'b10 :
            (rt_execute != '0 && rt_execute == write_register_writeback && register_write_writeback) ? 2'b01 : 2'b00;
    stall_fetch       = !reset && (mem_wait || hazard);
    stall_decode      = !reset && (mem_wait || hazard);
    stall_execute     = !reset && mem_wait;
    stall_memory      = !reset && mem_wait;
    flush_writeback   = !reset && mem_wait;
    flush_execute     = !reset && hazard;
    forward_decode_a  = !reset && rs_decode != '0 && rs_decode == write_register_memory && register_write_memory;
    forward_decode_b  = !reset && rt_decode != '0 && rt_decode == write_register_memory && register_write_memory;
    forward_execute_a = reset ? 2'b00 : fwd_a;
    forward_execute_b = reset ? 2'b00 : fwd_b;
    muldiv_busy       = !reset && busy;
    stall_cycles      = reset ? '0 : stall_cycles_q;
  end
  // HI/LO occupancy countdown and saturating stall counter next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && muldiv_start_execute && !mem_wait) begin
      state_d = BUSY;
      cnt_d   = muldiv_is_div_execute ? CNT_W'(DIV_LATENCY - 1) : CNT_W'(MULT_LATENCY - 1);
    end else if (state_q == BUSY) begin
      state_d = cnt_q == '0 ? IDLE : BUSY;
      cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1);
    end
    stall_cycles_d = (stall_fetch && stall_cycles_q != '1) ? stall_cycles_q + COUNT_W'(1) : stall_cycles_q;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed vectors checked through an expected-response queue
module tb_pipeline_hazard_controller;
  localparam int RW = 5;
  localparam int CW = 4;
  typedef struct packed {
    logic [3:0] st;
    logic       fe;
    logic       fw;
    logic [1:0] fd;
    logic [1:0] fea;
    logic [1:0] feb;
    logic       busy;
  } outs_t;
  typedef struct {
    string   name;
    outs_t   o;
    logic [CW-1:0] sc;
  } exp_t;
  logic clk = 0, reset;
  logic branch_decode, hilo_read_decode, muldiv_decode;
  logic [RW-1:0] rs_decode, rt_decode, rs_execute, rt_execute, write_register_execute;
  logic register_write_execute, memory_to_register_execute, muldiv_start_execute, muldiv_is_div_execute;
  logic [RW-1:0] write_register_memory, write_register_writeback;
  logic register_write_memory, memory_to_register_memory, mem_access_memory, mem_ready, register_write_writeback;
  logic stall_fetch, stall_decode, stall_execute, stall_memory, flush_execute, flush_writeback;
  logic forward_decode_a, forward_decode_b, muldiv_busy;
  logic [1:0] forward_execute_a, forward_execute_b;
  logic [CW-1:0] stall_cycles;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [CW-1:0] sc_exp;
  outs_t act;

  pipeline_hazard_controller #(.REG_ADDR_W(RW), .MULT_LATENCY(4), .DIV_LATENCY(32), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .branch_decode(branch_decode), .hilo_read_decode(hilo_read_decode), .muldiv_decode(muldiv_decode),
    .rs_decode(rs_decode), .rt_decode(rt_decode), .rs_execute(rs_execute), .rt_execute(rt_execute),
    .write_register_execute(write_register_execute), .register_write_execute(register_write_execute),
    .memory_to_register_execute(memory_to_register_execute), .muldiv_start_execute(muldiv_start_execute),
    .muldiv_is_div_execute(muldiv_is_div_execute), .write_register_memory(write_register_memory),
    .register_write_memory(register_write_memory), .memory_to_register_memory(memory_to_register_memory),
    .mem_access_memory(mem_access_memory), .mem_ready(mem_ready),
    .write_register_writeback(write_register_writeback), .register_write_writeback(register_write_writeback),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode), .stall_execute(stall_execute),
    .stall_memory(stall_memory), .flush_execute(flush_execute), .flush_writeback(flush_writeback),
    .forward_decode_a(forward_decode_a), .forward_decode_b(forward_decode_b),
    .forward_execute_a(forward_execute_a), .forward_execute_b(forward_execute_b),
    .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic outs_t mk(logic [3:0] st, logic fe, logic fw, logic [1:0] fd, logic [1:0] fea, logic [1:0] feb, logic b);
    mk = '{st, fe, fw, fd, fea, feb, b};
  endfunction

  localparam outs_t NONE = '0;
  outs_t HZ, HZB, MW, MWB;

  assign act = '{{stall_fetch, stall_decode, stall_execute, stall_memory}, flush_execute, flush_writeback,
                 {forward_decode_a, forward_decode_b}, forward_execute_a, forward_execute_b, muldiv_busy};

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (act !== e.o || stall_cycles !== e.sc) begin
        errors++;
        $display("FAIL %s: got outs=%b sc=%0d, expected outs=%b sc=%0d", e.name, act, stall_cycles, e.o, e.sc);
      end
    end
  end

  always @(posedge clk) begin
    if (!reset && muldiv_busy && muldiv_start_execute) begin
      errors++;
      $display("FAIL start_while_busy: got start=1 busy=1, expected no start while busy");
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic clr();
    branch_decode = 0; hilo_read_decode = 0; muldiv_decode = 0;
    rs_decode = 0; rt_decode = 0; rs_execute = 0; rt_execute = 0;
    write_register_execute = 0; register_write_execute = 0; memory_to_register_execute = 0;
    muldiv_start_execute = 0; muldiv_is_div_execute = 0;
    write_register_memory = 0; register_write_memory = 0; memory_to_register_memory = 0;
    mem_access_memory = 0; mem_ready = 1; write_register_writeback = 0; register_write_writeback = 0;
  endtask

  task automatic step(input string name, input outs_t e);
    q.push_back('{name, e, reset ? CW'(0) : sc_exp});
    @(posedge clk);
    sc_exp = reset ? '0 : (e.st[3] && sc_exp != '1) ? sc_exp + CW'(1) : sc_exp;
    #1;
  endtask

  initial begin
    HZ  = mk(4'b1100, 1, 0, 2'b00, 2'b00, 2'b00, 0);
    HZB = mk(4'b1100, 1, 0, 2'b00, 2'b00, 2'b00, 1);
    MW  = mk(4'b1111, 0, 1, 2'b00, 2'b00, 2'b00, 0);
    MWB = mk(4'b1111, 0, 1, 2'b00, 2'b00, 2'b00, 1);
    sc_exp = '0;
    reset = 1; clr();
    @(posedge clk); #1;
    step("reset", NONE);
    reset = 0;
    rs_execute = 5; write_register_memory = 5; register_write_memory = 1;
    write_register_writeback = 5; register_write_writeback = 1;
    step("fwd_mem_wins", mk(0, 0, 0, 0, 2'b10, 2'b00, 0));
    rt_execute = 5;
    step("fwd_both", mk(0, 0, 0, 0, 2'b10, 2'b10, 0));
    register_write_memory = 0;
    step("fwd_wb", mk(0, 0, 0, 0, 2'b01, 2'b01, 0));
    clr(); register_write_memory = 1; register_write_writeback = 1;
    step("fwd_r0", NONE);
    clr(); rs_decode = 5; rt_decode = 5; write_register_memory = 5; register_write_memory = 1;
    step("fwd_id", mk(0, 0, 0, 2'b11, 0, 0, 0));
    register_write_memory = 0;
    step("fwd_id_nowrite", NONE);
    clr(); memory_to_register_execute = 1; rt_execute = 3; rt_decode = 3;
    step("loaduse", HZ);
    memory_to_register_execute = 0;
    step("loaduse_done", NONE);
    memory_to_register_execute = 1; rt_execute = 0; rt_decode = 0;
    step("loaduse_r0", NONE);
    clr(); branch_decode = 1; rs_decode = 4; register_write_execute = 1; write_register_execute = 4;
    step("br_ex", HZ);
    clr(); branch_decode = 1; rt_decode = 6; memory_to_register_memory = 1;
    write_register_memory = 6; register_write_memory = 1;
    step("br_mem", mk(4'b1100, 1, 0, 2'b01, 0, 0, 0));
    clr(); memory_to_register_execute = 1; rt_execute = 3; rs_decode = 3;
    mem_access_memory = 1; mem_ready = 0;
    repeat (3) step("memwait", MW);
    mem_ready = 1;
    step("loaduse_after_wait", HZ);
    clr(); mem_access_memory = 1; mem_ready = 0; muldiv_start_execute = 1; muldiv_is_div_execute = 1;
    step("memwait_start", MW);
    clr();
    step("start_blocked", NONE);
    muldiv_start_execute = 1;
    step("mult_start", NONE);
    clr(); hilo_read_decode = 1;
    step("mult_busy1", HZB);
    mem_access_memory = 1; mem_ready = 0;
    step("mult_busy2_memwait", MWB);
    mem_access_memory = 0; mem_ready = 1; hilo_read_decode = 0; muldiv_decode = 1;
    step("mult_busy3", HZB);
    muldiv_decode = 0; hilo_read_decode = 1;
    step("mult_busy4", HZB);
    step("mult_done", NONE);
    clr(); muldiv_start_execute = 1; muldiv_is_div_execute = 1;
    step("div_start", NONE);
    clr(); hilo_read_decode = 1;
    repeat (32) step("div_busy", HZB);
    step("div_done", NONE);
    clr(); muldiv_start_execute = 1; muldiv_is_div_execute = 1;
    step("div2_start", NONE);
    clr(); hilo_read_decode = 1;
    repeat (9) step("div2_busy", HZB);
    reset = 1;
    step("reset_mid_div", NONE);
    reset = 0;
    step("after_reset", NONE);
    clr(); memory_to_register_execute = 1; rt_execute = 3; rt_decode = 3;
    repeat (18) step("sat_stall", HZ);
    clr();
    step("sat_hold", NONE);
    step("sat_hold2", NONE);
    @(negedge clk); #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
